// File: rtl/vector_scalar_mult_pkg.sv
// Shared types and defaults for the vector-scalar multiplier stage.
// The state encoding matches the vector adder so later vector stages can reuse it.
package vector_scalar_mult_pkg;

    localparam int DEF_VECTOR_LEN        = 5;
    localparam int DEF_VECTOR_CELL_WIDTH = 8;
    localparam int DEF_SCALAR_WIDTH      = 8;
    localparam int DEF_RESULT_CELL_WIDTH = 8;
    localparam int DEF_FRACTION_WIDTH    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2. Returns 0 for x <= 1.
    function automatic int log2(input int x);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < x) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vector_scalar_mult_if.sv
// Operand and result handshake bundle for vector_scalar_mult.
// The slave modport is the multiplier side, the master modport is its driver.
interface vector_scalar_mult_if
    import vector_scalar_mult_pkg::*;
#(
    parameter int VECTOR_LEN        = DEF_VECTOR_LEN,
    parameter int VECTOR_CELL_WIDTH = DEF_VECTOR_CELL_WIDTH,
    parameter int SCALAR_WIDTH      = DEF_SCALAR_WIDTH,
    parameter int RESULT_CELL_WIDTH = DEF_RESULT_CELL_WIDTH
);
    logic [VECTOR_LEN*VECTOR_CELL_WIDTH-1:0] vector;
    logic                                    vector_valid;
    logic                                    vector_ready;
    logic [SCALAR_WIDTH-1:0]                 scalar;
    logic                                    scalar_valid;
    logic                                    scalar_ready;
    logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result;
    logic                                    result_valid;
    logic                                    result_ready;
    logic                                    error;

    modport master (
        output vector, vector_valid, scalar, scalar_valid, result_ready,
        input  vector_ready, scalar_ready, result, result_valid, error
    );

    modport slave (
        input  vector, vector_valid, scalar, scalar_valid, result_ready,
        output vector_ready, scalar_ready, result, result_valid, error
    );
endinterface

// File: rtl/vector_scalar_mult_fixed_mult_sat.sv
// One combinational lane: signed fixed-point multiply, arithmetic right shift,
// saturation to the result width and an overflow flag gated by the lane enable.
module fixed_mult_sat
    import vector_scalar_mult_pkg::*;
#(
    parameter int VECTOR_CELL_WIDTH = DEF_VECTOR_CELL_WIDTH,
    parameter int SCALAR_WIDTH      = DEF_SCALAR_WIDTH,
    parameter int RESULT_CELL_WIDTH = DEF_RESULT_CELL_WIDTH,
    parameter int FRACTION_WIDTH    = DEF_FRACTION_WIDTH
)(
    input  logic [VECTOR_CELL_WIDTH-1:0] a_i,
    input  logic [SCALAR_WIDTH-1:0]      b_i,
    input  logic                         en_i,
    output logic [RESULT_CELL_WIDTH-1:0] res_o,
    output logic                         err_o
);
    localparam int PW = VECTOR_CELL_WIDTH + SCALAR_WIDTH;
    localparam logic signed [PW-1:0] MAXV = PW'((1 << (RESULT_CELL_WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] MINV = ~MAXV;

    logic signed [PW-1:0] a_ext, b_ext, prod, shf;

    // Operands are widened to the full product width so the multiply cannot wrap.
    assign a_ext = {{SCALAR_WIDTH{a_i[VECTOR_CELL_WIDTH-1]}}, a_i};
    assign b_ext = {{VECTOR_CELL_WIDTH{b_i[SCALAR_WIDTH-1]}}, b_i};
    assign prod  = a_ext * b_ext;
    assign shf   = prod >>> FRACTION_WIDTH;

    always_comb begin
        res_o = shf[RESULT_CELL_WIDTH-1:0];
        err_o = 1'b0;
        if (shf > MAXV) begin
            res_o = MAXV[RESULT_CELL_WIDTH-1:0];
            err_o = en_i;
        end else if (shf < MINV) begin
            res_o = MINV[RESULT_CELL_WIDTH-1:0];
            err_o = en_i;
        end
    end
endmodule

// File: rtl/vector_scalar_mult.sv
// Vector times scalar with saturation, TILING lanes per cycle, feeding the
// weight-update adder. Collects both operands in IDLE, sweeps lanes in CALC, holds in DONE.
module vector_scalar_mult
    import vector_scalar_mult_pkg::*;
#(
    parameter int VECTOR_LEN        = DEF_VECTOR_LEN,
    parameter int VECTOR_CELL_WIDTH = DEF_VECTOR_CELL_WIDTH,
    parameter int SCALAR_WIDTH      = DEF_SCALAR_WIDTH,
    parameter int RESULT_CELL_WIDTH = DEF_RESULT_CELL_WIDTH,
    parameter int FRACTION_WIDTH    = DEF_FRACTION_WIDTH,
    parameter int TILING            = 1
)(
    input  logic                 clk,
    input  logic                 rst,
    vector_scalar_mult_if.slave  bus
);
    localparam int CNT_W = log2(VECTOR_LEN) + 1;

    state_t                                              state_q, state_d;
    logic [CNT_W-1:0]                                    cnt_q, cnt_d;
    logic [VECTOR_LEN-1:0][VECTOR_CELL_WIDTH-1:0]        vec_q, vec_d;
    logic [SCALAR_WIDTH-1:0]                             scl_q, scl_d;
    logic                                                vset_q, vset_d;
    logic                                                sset_q, sset_d;
    logic [VECTOR_LEN-1:0][RESULT_CELL_WIDTH-1:0]        res_q, res_d;
    logic                                                err_q, err_d;

    logic [TILING-1:0][31:0]                             lane_idx;
    logic [TILING-1:0]                                   lane_en;
    logic [TILING-1:0]                                   lane_err;
    logic [TILING-1:0][VECTOR_CELL_WIDTH-1:0]            lane_a;
    logic [TILING-1:0][RESULT_CELL_WIDTH-1:0]            lane_res;

    // Lanes past the end of the vector see a zero operand and are disabled,
    // so the last partial tile never reads or writes outside the vector.
    always_comb begin
        for (int t = 0; t < TILING; t++) begin
            lane_idx[t] = 32'(cnt_q) + 32'(t);
            lane_en[t]  = lane_idx[t] < 32'(VECTOR_LEN);
            lane_a[t]   = '0;
            for (int i = 0; i < VECTOR_LEN; i++) begin
                if (lane_idx[t] == 32'(i)) lane_a[t] = vec_q[i];
            end
        end
    end

    generate
        for (genvar t = 0; t < TILING; t++) begin : g_lane
            fixed_mult_sat #(
                .VECTOR_CELL_WIDTH (VECTOR_CELL_WIDTH),
                .SCALAR_WIDTH      (SCALAR_WIDTH),
                .RESULT_CELL_WIDTH (RESULT_CELL_WIDTH),
                .FRACTION_WIDTH    (FRACTION_WIDTH)
            ) u_lane (
                .a_i   (lane_a[t]),
                .b_i   (scl_q),
                .en_i  (lane_en[t]),
                .res_o (lane_res[t]),
                .err_o (lane_err[t])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        scl_d   = scl_q;
        vset_d  = vset_q;
        sset_d  = sset_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (vset_q && sset_q) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    res_d   = '0;
                    err_d   = 1'b0;
                end else begin
                    if (bus.vector_valid && !vset_q) begin
                        vset_d = 1'b1;
                        vec_d  = bus.vector;
                    end
                    if (bus.scalar_valid && !sset_q) begin
                        sset_d = 1'b1;
                        scl_d  = bus.scalar;
                    end
                end
            end
            CALC: begin
                for (int t = 0; t < TILING; t++) begin
                    for (int i = 0; i < VECTOR_LEN; i++) begin
                        if (lane_en[t] && lane_idx[t] == 32'(i)) res_d[i] = lane_res[t];
                    end
                end
                err_d = err_q | (|lane_err);
                cnt_d = cnt_q + CNT_W'(TILING);
                if (32'(cnt_q) + 32'(TILING) >= 32'(VECTOR_LEN)) state_d = DONE;
            end
            DONE: begin
                if (bus.result_ready) begin
                    state_d = IDLE;
                    vset_d  = 1'b0;
                    sset_d  = 1'b0;
                    vec_d   = '0;
                    scl_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            scl_q   <= '0;
            vset_q  <= 1'b0;
            sset_q  <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            scl_q   <= scl_d;
            vset_q  <= vset_d;
            sset_q  <= sset_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign bus.vector_ready = !vset_q;
    assign bus.scalar_ready = !sset_q;
    assign bus.result       = res_q;
    assign bus.result_valid = (state_q == DONE);
    assign bus.error        = err_q;
endmodule

// File: tb/tb_vector_scalar_mult.sv
// Bench for vector_scalar_mult: TILING=1 and TILING=2 instances share stimulus and are
// compared each cycle against a transaction-level model, plus literal expectations.
module tb_vector_scalar_mult;
    localparam int VL = 5;
    localparam int VW = 8;
    localparam int SW = 8;
    localparam int RW = 8;
    localparam int FW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [VL*VW-1:0] vec;
    logic             vvld;
    logic [SW-1:0]    scl;
    logic             svld;
    logic             rrdy;

    vector_scalar_mult_if #(.VECTOR_LEN(VL), .VECTOR_CELL_WIDTH(VW), .SCALAR_WIDTH(SW), .RESULT_CELL_WIDTH(RW)) if0 ();
    vector_scalar_mult_if #(.VECTOR_LEN(VL), .VECTOR_CELL_WIDTH(VW), .SCALAR_WIDTH(SW), .RESULT_CELL_WIDTH(RW)) if1 ();

    assign if0.vector = vec;  assign if0.vector_valid = vvld;  assign if0.scalar = scl;
    assign if0.scalar_valid = svld;  assign if0.result_ready = rrdy;
    assign if1.vector = vec;  assign if1.vector_valid = vvld;  assign if1.scalar = scl;
    assign if1.scalar_valid = svld;  assign if1.result_ready = rrdy;

    vector_scalar_mult #(.VECTOR_LEN(VL), .VECTOR_CELL_WIDTH(VW), .SCALAR_WIDTH(SW),
        .RESULT_CELL_WIDTH(RW), .FRACTION_WIDTH(FW), .TILING(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    vector_scalar_mult #(.VECTOR_LEN(VL), .VECTOR_CELL_WIDTH(VW), .SCALAR_WIDTH(SW),
        .RESULT_CELL_WIDTH(RW), .FRACTION_WIDTH(FW), .TILING(2)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    logic             o_rv [2];
    logic             o_vr [2];
    logic             o_sr [2];
    logic             o_er [2];
    logic [VL*RW-1:0] o_res[2];
    assign o_rv[0] = if0.result_valid;  assign o_rv[1] = if1.result_valid;
    assign o_vr[0] = if0.vector_ready;  assign o_vr[1] = if1.vector_ready;
    assign o_sr[0] = if0.scalar_ready;  assign o_sr[1] = if1.scalar_ready;
    assign o_er[0] = if0.error;         assign o_er[1] = if1.error;
    assign o_res[0] = if0.result;       assign o_res[1] = if1.result;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [VL*VW-1:0] pk(input int c0, input int c1, input int c2, input int c3, input int c4);
        logic [VL*VW-1:0] r;
        r = {VW'(c4), VW'(c3), VW'(c2), VW'(c1), VW'(c0)};
        return r;
    endfunction

    // Reference arithmetic: full-precision integer product, floor shift, clamp.
    function automatic logic [VL*RW:0] golden(input logic [VL*VW-1:0] v, input logic [SW-1:0] s);
        logic [VL*RW-1:0] r;
        bit e;
        int a, b, q, hi, lo;
        hi = (1 << (RW - 1)) - 1;
        lo = -hi - 1;
        r  = '0;
        e  = 1'b0;
        b  = int'($signed(s));
        for (int i = 0; i < VL; i++) begin
            a = int'($signed(v[i*VW +: VW]));
            q = (a * b) >>> FW;
            if (q > hi) begin q = hi; e = 1'b1; end
            else if (q < lo) begin q = lo; e = 1'b1; end
            r[i*RW +: RW] = RW'(q);
        end
        return {e, r};
    endfunction

    function automatic int ncalc(input int d);
        int t;
        t = (d == 0) ? 1 : 2;
        return (VL + t - 1) / t;
    endfunction

    // Transaction model: 0 = collecting operands, 1 = computing, 2 = result offered.
    int               ph  [2];
    int               cnt [2];
    bit               vs  [2];
    bit               ss  [2];
    logic [VL*VW-1:0] mv  [2];
    logic [SW-1:0]    ms  [2];
    logic [VL*RW-1:0] mres[2];
    bit               merr[2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                ph[d] <= 0;  vs[d] <= 1'b0;  ss[d] <= 1'b0;
                mres[d] <= '0;  merr[d] <= 1'b0;  cnt[d] <= 0;
            end else begin
                case (ph[d])
                    0: begin
                        if (vs[d] && ss[d]) begin
                            ph[d] <= 1;  cnt[d] <= ncalc(d);
                            mres[d] <= '0;  merr[d] <= 1'b0;
                        end else begin
                            if (vvld && !vs[d]) begin vs[d] <= 1'b1; mv[d] <= vec; end
                            if (svld && !ss[d]) begin ss[d] <= 1'b1; ms[d] <= scl; end
                        end
                    end
                    1: begin
                        cnt[d] <= cnt[d] - 1;
                        if (cnt[d] == 1) begin
                            ph[d] <= 2;
                            {merr[d], mres[d]} <= golden(mv[d], ms[d]);
                        end
                    end
                    default: if (rrdy) begin ph[d] <= 0; vs[d] <= 1'b0; ss[d] <= 1'b0; end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("mdl_rvalid%0d", d), 64'(o_rv[d]), 64'(ph[d] == 2));
                chk($sformatf("mdl_vready%0d", d), 64'(o_vr[d]), 64'(!vs[d]));
                chk($sformatf("mdl_sready%0d", d), 64'(o_sr[d]), 64'(!ss[d]));
                if (ph[d] != 1) begin
                    chk($sformatf("mdl_result%0d", d), 64'(o_res[d]), 64'(mres[d]));
                    chk($sformatf("mdl_error%0d", d), 64'(o_er[d]), 64'(merr[d]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns after the edge that captured the last operand, with all valids low.
    task automatic drive_ops(input logic [VL*VW-1:0] v, input logic [SW-1:0] s, input int order);
        if (order == 0) begin
            vec = v;  scl = s;  vvld = 1'b1;  svld = 1'b1;
            tick();
            vvld = 1'b0;  svld = 1'b0;
        end else if (order == 1) begin
            scl = s;  svld = 1'b1;
            tick();
            scl = s ^ 8'h5A;
            for (int k = 0; k < 5; k++) begin
                chk("scalar_first_sready", 64'(if0.scalar_ready), 64'(0));
                tick();
            end
            svld = 1'b0;  vec = v;  vvld = 1'b1;
            tick();
            vvld = 1'b0;
        end else begin
            vec = v;  vvld = 1'b1;
            tick();
            vec = ~v;
            for (int k = 0; k < 5; k++) begin
                chk("vector_first_vready", 64'(if0.vector_ready), 64'(0));
                tick();
            end
            vvld = 1'b0;  scl = s;  svld = 1'b1;
            tick();
            svld = 1'b0;
        end
    endtask

    task automatic wait_result(output int e0, output int e1);
        e0 = -1;
        e1 = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (e1 < 0 && if1.result_valid) e1 = k;
            if (if0.result_valid) begin
                e0 = k;
                break;
            end
        end
        if (e0 < 0) chk("result_valid_timeout", 64'(0), 64'(1));
    endtask

    task automatic check_lit(input string n, input logic [VL*RW-1:0] r, input bit e);
        chk({n, "_res0"}, 64'(if0.result), 64'(r));
        chk({n, "_res1"}, 64'(if1.result), 64'(r));
        chk({n, "_err0"}, 64'(if0.error), 64'(e));
        chk({n, "_err1"}, 64'(if1.error), 64'(e));
    endtask

    task automatic handshake();
        rrdy = 1'b1;
        tick();
        rrdy = 1'b0;
    endtask

    task automatic check_idle_clear(input string n);
        chk({n, "_rvalid"}, 64'(if0.result_valid | if1.result_valid), 64'(0));
        chk({n, "_result"}, 64'(if0.result | if1.result), 64'(0));
        chk({n, "_err"},    64'(if0.error | if1.error), 64'(0));
        chk({n, "_readys"}, 64'({if0.vector_ready, if0.scalar_ready, if1.vector_ready, if1.scalar_ready}), 64'(4'hF));
    endtask

    initial begin
        logic [VL*VW-1:0] vb, vs_, v5;
        logic [VL*RW-1:0] rb, rs, r5;
        logic [63:0]      rnd;
        int e0, e1;

        vb  = pk(16, 32, -16, 8, 127);   rb = pk(8, 16, -8, 4, 63);
        vs_ = pk(127, -128, 1, 0, -1);   rs = pk(127, -128, 7, 0, -8);
        v5  = pk(16, 32, 48, 64, 80);    r5 = pk(16, 32, 48, 64, 80);

        rst = 1'b1;  vvld = 1'b0;  svld = 1'b0;  rrdy = 1'b0;  vec = '0;  scl = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        check_idle_clear("reset");

        chk("gold_basic", 64'(golden(vb, 8'd8)), 64'({1'b0, rb}));
        chk("gold_sat",   64'(golden(vs_, 8'd127)), 64'({1'b1, rs}));
        chk("gold_tile",  64'(golden(v5, 8'd16)), 64'({1'b0, r5}));

        drive_ops(vb, 8'd8, 0);
        wait_result(e0, e1);
        chk("basic_lat0", 64'(e0), 64'(6));
        chk("basic_lat1", 64'(e1), 64'(4));
        check_lit("basic", rb, 1'b0);
        handshake();

        drive_ops(vs_, 8'd127, 0);
        wait_result(e0, e1);
        check_lit("sat", rs, 1'b1);
        handshake();

        drive_ops(vb, 8'd8, 0);
        wait_result(e0, e1);
        check_lit("err_clear", rb, 1'b0);
        handshake();

        for (int o = 1; o <= 2; o++) begin
            drive_ops(vb, 8'd8, o);
            wait_result(e0, e1);
            chk($sformatf("order%0d_lat0", o), 64'(e0), 64'(6));
            check_lit($sformatf("order%0d", o), rb, 1'b0);
            handshake();
        end

        // Back-pressure: new vector offered while the result is held.
        drive_ops(vb, 8'd8, 0);
        wait_result(e0, e1);
        vec = v5;  vvld = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_vready", 64'({if0.vector_ready, if1.vector_ready}), 64'(0));
            chk("bp_rvalid", 64'({if0.result_valid, if1.result_valid}), 64'(2'b11));
            check_lit("bp_hold", rb, 1'b0);
        end
        handshake();
        chk("bp_vready_after", 64'(if0.vector_ready), 64'(1));
        tick();
        vvld = 1'b0;
        chk("bp_captured", 64'(if0.vector_ready), 64'(0));
        scl = 8'd16;  svld = 1'b1;
        tick();
        svld = 1'b0;
        wait_result(e0, e1);
        chk("tile_lat0", 64'(e0), 64'(6));
        chk("tile_lat1", 64'(e1), 64'(4));
        check_lit("tile", r5, 1'b0);
        handshake();

        // Reset during the second CALC cycle.
        drive_ops(vb, 8'd8, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_clear("mid_rst");
        drive_ops(vs_, 8'd127, 0);
        wait_result(e0, e1);
        chk("post_rst_lat0", 64'(e0), 64'(6));
        check_lit("post_rst", rs, 1'b1);
        handshake();

        for (int c = 0; c < 3000; c++) begin
            tick();
            rnd  = {$urandom(), $urandom()};
            vec  = rnd[VL*VW-1:0];
            vvld = ($urandom_range(0, 3) == 0);
            scl  = ($urandom_range(0, 1) == 0) ? SW'($urandom()) : SW'($urandom_range(0, 24));
            svld = ($urandom_range(0, 3) == 0);
            rrdy = ($urandom_range(0, 2) == 0);
            rst  = ($urandom_range(0, 499) == 0);
        end
        vvld = 1'b0;  svld = 1'b0;  rst = 1'b0;  rrdy = 1'b1;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
